// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_arb_pkg;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RD   = 1'b1
  } state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; mask removes the core from eligibility.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       mask,
  output logic [1:0] win,
  output logic       win_id
);
  logic [1:0] elig;

  always_comb begin
    elig   = {req[1], req[0] & ~mask};
    win_id = REQ_CORE;
    win    = 2'b00;
    if (elig == 2'b11) win_id = prio;
    else               win_id = elig[1];
    if (|elig) win = (win_id == REQ_DBG) ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core and the debug loader,
// round-robin with a debug lock for atomic multi-access sequences.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  core_wait_cnt
);
  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       win;
  logic             win_id;
  logic             win_we;

  rr_arb2 u_arb (
    .req    ({dbg_req, core_req}),
    .prio   (prio_q),
    .mask   (locked_q),
    .win    (win),
    .win_id (win_id)
  );

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    locked_d    = locked_q;
    cnt_d       = cnt_q;
    win_we      = 1'b0;
    core_gnt    = 1'b0;
    dbg_gnt     = 1'b0;
    core_rvalid = 1'b0;
    dbg_rvalid  = 1'b0;
    core_rdata  = '0;
    dbg_rdata   = '0;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    case (state_q)
      S_IDLE: begin
        if (|win) begin
          win_we    = (win_id == REQ_DBG) ? dbg_we : core_we;
          mem_addr  = (win_id == REQ_DBG) ? dbg_addr : core_addr;
          mem_wdata = (win_id == REQ_DBG) ? dbg_wdata : core_wdata;
          mem_wr    = win_we;
          mem_rd    = ~win_we;
          core_gnt  = win[0];
          dbg_gnt   = win[1];
          prio_d    = ~win_id;
          if (!win_we) begin
            owner_d = win_id;
            state_d = S_RD;
          end
        end
        // Lock is (re)armed by a locked debug grant, dropped on any idle cycle without dbg_lock.
        if (win[1] && dbg_lock) locked_d = 1'b1;
        else if (!dbg_lock)     locked_d = 1'b0;
      end
      S_RD: begin
        state_d = S_IDLE;
        if (owner_q == REQ_DBG) begin
          dbg_rvalid = 1'b1;
          dbg_rdata  = mem_rdata;
        end else begin
          core_rvalid = 1'b1;
          core_rdata  = mem_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (core_req && !core_gnt && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;

    busy          = (state_q == S_RD) || locked_q;
    core_wait_cnt = cnt_q;

    // Reset blanks every output so an aborted read never surfaces.
    if (!reset) begin
      core_gnt      = 1'b0;
      dbg_gnt       = 1'b0;
      core_rvalid   = 1'b0;
      dbg_rvalid    = 1'b0;
      core_rdata    = '0;
      dbg_rdata     = '0;
      mem_wr        = 1'b0;
      mem_rd        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      busy          = 1'b0;
      core_wait_cnt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      prio_q   <= REQ_CORE;
      owner_q  <= REQ_CORE;
      locked_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Cycle-by-cycle vector bench for dmem_arbiter with a read-data scoreboard.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int CW = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we, core_gnt, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_wr, mem_rd, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] core_wait_cnt;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .core_wait_cnt(core_wait_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after mem_rd, garbage otherwise.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_rd ? ram[mem_addr] : 32'hBAD0_BAD0;
  end

  typedef struct {
    logic rst, creq, cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwdata;
    logic dreq, dwe, dlock;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic egc, egd, ebusy;
  } vec_t;

  typedef struct {
    logic id;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           sb[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            n_chk, n_fail, cnt_m;

  function automatic vec_t mk(logic rst, logic creq, logic cwe, logic [AW-1:0] caddr,
                              logic [DW-1:0] cwdata, logic dreq, logic dwe, logic dlock,
                              logic [AW-1:0] daddr, logic [DW-1:0] dwdata,
                              logic egc, logic egd, logic ebusy);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwdata = cwdata;
    v.dreq = dreq; v.dwe = dwe; v.dlock = dlock; v.daddr = daddr; v.dwdata = dwdata;
    v.egc = egc; v.egd = egd; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, rdc, rdd;
    logic          ewr, erd, rvc, rvd;
    rd_t           e;
    reset = v.rst; core_req = v.creq; core_we = v.cwe; core_addr = v.caddr;
    core_wdata = v.cwdata; dbg_req = v.dreq; dbg_we = v.dwe; dbg_lock = v.dlock;
    dbg_addr = v.daddr; dbg_wdata = v.dwdata;
    if (!v.rst) sb.delete();
    @(negedge clk);
    ewr = 1'b0; erd = 1'b0; ea = '0; ed = '0;
    if (v.rst && v.egc) begin
      ewr = v.cwe; erd = !v.cwe; ea = v.caddr; ed = v.cwdata;
    end else if (v.rst && v.egd) begin
      ewr = v.dwe; erd = !v.dwe; ea = v.daddr; ed = v.dwdata;
    end
    rvc = 1'b0; rvd = 1'b0; rdc = '0; rdd = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.id) begin rvd = 1'b1; rdd = e.data; end
      else      begin rvc = 1'b1; rdc = e.data; end
    end
    chk("core_gnt",    64'(core_gnt),    64'(v.rst & v.egc));
    chk("dbg_gnt",     64'(dbg_gnt),     64'(v.rst & v.egd));
    chk("mem_wr",      64'(mem_wr),      64'(ewr));
    chk("mem_rd",      64'(mem_rd),      64'(erd));
    chk("mem_addr",    64'(mem_addr),    64'(ea));
    chk("mem_wdata",   64'(mem_wdata),   64'(ed));
    chk("busy",        64'(busy),        64'(v.rst & v.ebusy));
    chk("core_rvalid", 64'(core_rvalid), 64'(rvc));
    chk("core_rdata",  64'(core_rdata),  64'(rdc));
    chk("dbg_rvalid",  64'(dbg_rvalid),  64'(rvd));
    chk("dbg_rdata",   64'(dbg_rdata),   64'(rdd));
    chk("wait_cnt",    64'(core_wait_cnt), v.rst ? 64'(cnt_m) : 64'd0);
    if (v.rst && (v.egc || v.egd)) begin
      if (erd) begin
        e.id = v.egd; e.data = shadow[ea];
        sb.push_back(e);
      end else begin
        shadow[ea] = ed;
      end
    end
    if (!v.rst) cnt_m = 0;
    else if (v.creq && !v.egc && cnt_m < 15) cnt_m++;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[$];
    n_chk = 0; n_fail = 0; cnt_m = 0;
    reset = 1'b0; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;

    //             rst creq cwe caddr   cwdata        dreq dwe dlk daddr   dwdata        gc gd busy
    tv.push_back(mk(L, H, H, 9'h005, 32'hDEADBEEF, H, H, L, 9'h007, 32'h11111111, L, L, L));
    tv.push_back(mk(L, L, L, 9'h000, 32'h0,        L, L, L, 9'h000, 32'h0,        L, L, L));
    tv.push_back(mk(H, H, H, 9'h005, 32'hDEADBEEF, L, L, L, 9'h000, 32'h0,        H, L, L));
    tv.push_back(mk(H, L, L, 9'h000, 32'h0,        L, L, L, 9'h000, 32'h0,        L, L, L));
    tv.push_back(mk(H, H, L, 9'h005, 32'h0,        L, L, L, 9'h000, 32'h0,        H, L, L));
    tv.push_back(mk(H, L, L, 9'h000, 32'h0,        H, H, L, 9'h007, 32'h11111111, L, L, H));
    tv.push_back(mk(H, L, L, 9'h000, 32'h0,        H, H, L, 9'h007, 32'h11111111, L, H, L));
    tv.push_back(mk(H, H, H, 9'h010, 32'hA0A0A0A0, H, H, L, 9'h011, 32'hB0B0B0B0, H, L, L));
    tv.push_back(mk(H, H, H, 9'h010, 32'hA1A1A1A1, H, H, L, 9'h011, 32'hB0B0B0B0, L, H, L));
    tv.push_back(mk(H, H, H, 9'h010, 32'hA1A1A1A1, H, H, L, 9'h011, 32'hB1B1B1B1, H, L, L));
    tv.push_back(mk(H, H, H, 9'h010, 32'hA2A2A2A2, H, H, L, 9'h011, 32'hB1B1B1B1, L, H, L));
    tv.push_back(mk(H, H, H, 9'h010, 32'hA2A2A2A2, H, L, L, 9'h007, 32'h0,        H, L, L));
    tv.push_back(mk(H, L, L, 9'h000, 32'h0,        H, L, L, 9'h007, 32'h0,        L, H, L));
    tv.push_back(mk(H, H, L, 9'h005, 32'h0,        L, L, L, 9'h000, 32'h0,        L, L, H));
    tv.push_back(mk(H, H, L, 9'h005, 32'h0,        L, L, L, 9'h000, 32'h0,        H, L, L));
    tv.push_back(mk(H, L, L, 9'h000, 32'h0,        L, L, L, 9'h000, 32'h0,        L, L, H));
    tv.push_back(mk(H, H, H, 9'h021, 32'hD0D0D0D0, H, H, H, 9'h020, 32'hC0C0C0C0, L, H, L));
    tv.push_back(mk(H, H, H, 9'h021, 32'hD0D0D0D0, H, H, H, 9'h023, 32'hC1C1C1C1, L, H, H));
    tv.push_back(mk(H, H, H, 9'h021, 32'hD0D0D0D0, H, H, H, 9'h024, 32'hC2C2C2C2, L, H, H));
    tv.push_back(mk(H, H, H, 9'h021, 32'hD0D0D0D0, L, L, L, 9'h000, 32'h0,        L, L, H));
    tv.push_back(mk(H, H, H, 9'h021, 32'hD0D0D0D0, L, L, L, 9'h000, 32'h0,        H, L, L));
    tv.push_back(mk(H, L, L, 9'h000, 32'h0,        H, L, L, 9'h024, 32'h0,        L, H, L));
    tv.push_back(mk(H, L, L, 9'h000, 32'h0,        L, L, L, 9'h000, 32'h0,        L, L, H));
    tv.push_back(mk(H, H, L, 9'h023, 32'h0,        L, L, L, 9'h000, 32'h0,        H, L, L));
    tv.push_back(mk(L, L, L, 9'h000, 32'h0,        L, L, L, 9'h000, 32'h0,        L, L, L));
    tv.push_back(mk(H, L, L, 9'h000, 32'h0,        L, L, L, 9'h000, 32'h0,        L, L, L));
    foreach (tv[i]) apply(tv[i]);

    // Saturation: debug holds the lock while the core waits 20 cycles.
    apply(mk(H, L, L, 9'h000, 32'h0, H, H, H, 9'h030, 32'hE0E0E0E0, L, H, L));
    for (int i = 0; i < 20; i++)
      apply(mk(H, H, H, 9'h031, 32'hF0F0F0F0, L, L, H, 9'h000, 32'h0, L, L, H));
    chk("sat_cnt", 64'(core_wait_cnt), 64'd15);
    apply(mk(H, H, H, 9'h031, 32'hF0F0F0F0, L, L, L, 9'h000, 32'h0, L, L, H));
    apply(mk(H, H, H, 9'h031, 32'hF0F0F0F0, L, L, L, 9'h000, 32'h0, H, L, L));
    apply(mk(H, L, L, 9'h000, 32'h0,        H, L, L, 9'h031, 32'h0, L, H, L));
    apply(mk(H, L, L, 9'h000, 32'h0,        L, L, L, 9'h000, 32'h0, L, L, H));
    apply(mk(H, L, L, 9'h000, 32'h0,        L, L, L, 9'h000, 32'h0, L, L, L));
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
